// File: rtl/tdp_sync_fifo_ctl_pkg.sv
// Shared definitions for the two-lane synchronous FIFO controller.
package tdp_sync_fifo_pkg;

  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_HALF = 1'b1;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic underrun;
    logic full;
    logic almost_full;
    logic overrun;
  } fifo_flags_t;

  // Half-words moved by one operation in the given width mode.
  function automatic logic [1:0] op_size(input logic mode);
    return (mode == MODE_HALF) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/tdp_sync_fifo_ctl_if.sv
// Bundle of the FIFO data/handshake/status signals; the fabric side is master.
interface tdp_sync_fifo_ctl_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
);
  logic                  flush;
  logic                  wmode;
  logic                  rmode;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic [ADDR_WIDTH:0]   upaf;
  logic [ADDR_WIDTH:0]   upae;
  logic [ADDR_WIDTH+1:0] level;
  logic                  empty;
  logic                  almost_empty;
  logic                  underrun;
  logic                  full;
  logic                  almost_full;
  logic                  overrun;

  modport master (
    output flush, wmode, rmode, wen, wdata, ren, upaf, upae,
    input  rdata, rvalid, level, empty, almost_empty, underrun, full, almost_full, overrun
  );

  modport slave (
    input  flush, wmode, rmode, wen, wdata, ren, upaf, upae,
    output rdata, rvalid, level, empty, almost_empty, underrun, full, almost_full, overrun
  );
endinterface

// File: rtl/tdp_fifo_lane_mem.sv
// One half-word storage lane: DEPTH x HW, one write and one read port.
// Read is registered, or asynchronous when TDP_SYNC_FIFO_FWFT_EN is defined.
module tdp_fifo_lane_mem #(
    parameter int HW = 9,
    parameter int AW = 10
) (
    input  logic          clk_i,
`ifndef TDP_SYNC_FIFO_FWFT_EN
    input  logic          re_i,
`endif
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [HW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [HW-1:0] rdata_o
);
    localparam int DEPTH = 2 ** AW;

    logic [HW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

`ifdef TDP_SYNC_FIFO_FWFT_EN
    assign rdata_o = mem_q[raddr_i];
`else
    logic [HW-1:0] rdata_q;

    // Sampled before the same-edge write lands, so a colliding read sees old data.
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
`endif
endmodule

// File: rtl/tdp_sync_fifo_ctl.sv
// Two-lane synchronous FIFO with per-side full/half width, watermarks and sticky errors.
// Define TDP_SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module tdp_sync_fifo_ctl
    import tdp_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  FLUSH_i,
    input  logic                  WMODE_i,
    input  logic                  RMODE_i,
    input  logic                  WEN_i,
    input  logic [DATA_WIDTH-1:0] WDATA_i,
    input  logic                  REN_i,
    output logic [DATA_WIDTH-1:0] RDATA_o,
    output logic                  RVALID_o,
    input  logic [ADDR_WIDTH:0]   UPAF_i,
    input  logic [ADDR_WIDTH:0]   UPAE_i,
    output logic [ADDR_WIDTH+1:0] LEVEL_o,
    output logic                  EMPTY_o,
    output logic                  ALMOST_EMPTY_o,
    output logic                  UNDERRUN_o,
    output logic                  FULL_o,
    output logic                  ALMOST_FULL_o,
    output logic                  OVERRUN_o
);
    localparam int HW = DATA_WIDTH / 2;
    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [CW-1:0] TOTAL = {1'b1, {(CW-1){1'b0}}};

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_p1, rptr_p1;
    logic [CW-1:0] cnt_q, cnt_d, free_hw, wsize, rsize;
    logic          ovr_q, ovr_d, und_q, und_d;
    logic          clr, w_acc, r_acc;
    fifo_flags_t   flags;

    // Handshake: WEN_i/REN_i are requests; FULL_o/EMPTY_o act as the inverted ready
    // for the current width, a request with its ready low is dropped and flagged sticky.
    assign clr     = RST_i | FLUSH_i;
    assign wsize   = CW'(op_size(WMODE_i));
    assign rsize   = CW'(op_size(RMODE_i));
    assign free_hw = TOTAL - cnt_q;

    assign flags.empty        = cnt_q < rsize;
    assign flags.full         = free_hw < wsize;
    assign flags.almost_empty = cnt_q <= {1'b0, UPAE_i};
    assign flags.almost_full  = free_hw <= {1'b0, UPAF_i};
    assign flags.overrun      = ovr_q;
    assign flags.underrun     = und_q;

    assign w_acc = WEN_i & ~flags.full & ~clr;
    assign r_acc = REN_i & ~flags.empty & ~clr;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovr_d  = ovr_q;
        und_d  = und_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovr_d  = 1'b0;
            und_d  = 1'b0;
        end else begin
            if (w_acc) wptr_d = wptr_q + PW'(op_size(WMODE_i));
            if (r_acc) rptr_d = rptr_q + PW'(op_size(RMODE_i));
            cnt_d = cnt_q + (w_acc ? wsize : '0) - (r_acc ? rsize : '0);
            if (WEN_i & flags.full)  ovr_d = 1'b1;
            if (REN_i & flags.empty) und_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_i) begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
        ovr_q  <= ovr_d;
        und_q  <= und_d;
    end

    // Low half goes to lane p[0]; at odd p the high half lands in lane 0 of the next word.
    logic [ADDR_WIDTH-1:0] waddr0, waddr1, raddr0, raddr1;
    logic [HW-1:0]         wd0, wd1, rd0, rd1;
    logic                  we0, we1;

    assign wptr_p1 = wptr_q + 1'b1;
    assign rptr_p1 = rptr_q + 1'b1;
    assign waddr0  = wptr_q[0] ? wptr_p1[PW-1:1] : wptr_q[PW-1:1];
    assign waddr1  = wptr_q[PW-1:1];
    assign raddr0  = rptr_q[0] ? rptr_p1[PW-1:1] : rptr_q[PW-1:1];
    assign raddr1  = rptr_q[PW-1:1];
    assign we0     = w_acc & ((WMODE_i == MODE_FULL) | ~wptr_q[0]);
    assign we1     = w_acc & ((WMODE_i == MODE_FULL) | wptr_q[0]);
    assign wd0     = wptr_q[0] ? WDATA_i[DATA_WIDTH-1:HW] : WDATA_i[HW-1:0];
    assign wd1     = wptr_q[0] ? WDATA_i[HW-1:0] : WDATA_i[DATA_WIDTH-1:HW];

    tdp_fifo_lane_mem #(.HW(HW), .AW(ADDR_WIDTH)) u_lane0 (
        .clk_i   (CLK_i),
`ifndef TDP_SYNC_FIFO_FWFT_EN
        .re_i    (r_acc),
`endif
        .we_i    (we0),
        .waddr_i (waddr0),
        .wdata_i (wd0),
        .raddr_i (raddr0),
        .rdata_o (rd0)
    );

    tdp_fifo_lane_mem #(.HW(HW), .AW(ADDR_WIDTH)) u_lane1 (
        .clk_i   (CLK_i),
`ifndef TDP_SYNC_FIFO_FWFT_EN
        .re_i    (r_acc),
`endif
        .we_i    (we1),
        .waddr_i (waddr1),
        .wdata_i (wd1),
        .raddr_i (raddr1),
        .rdata_o (rd1)
    );

    logic          rsel, rhalf;
    logic [HW-1:0] lo_hw, hi_hw;
    logic [DATA_WIDTH-1:0] rdata_asm;

    assign lo_hw     = rsel ? rd1 : rd0;
    assign hi_hw     = rsel ? rd0 : rd1;
    assign rdata_asm = rhalf ? {{(DATA_WIDTH-HW){1'b0}}, lo_hw} : {hi_hw, lo_hw};

`ifdef TDP_SYNC_FIFO_FWFT_EN
    assign rsel     = rptr_q[0];
    assign rhalf    = RMODE_i;
    assign RDATA_o  = rdata_asm;
    assign RVALID_o = ~flags.empty;
`else
    logic rsel_q, rhalf_q, have_q, rvalid_q;

    // Lane outputs hold between reads; have_q masks them to zero until the first pop.
    always_ff @(posedge CLK_i) begin
        if (clr) begin
            rsel_q   <= 1'b0;
            rhalf_q  <= 1'b0;
            have_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= r_acc;
            if (r_acc) begin
                rsel_q  <= rptr_q[0];
                rhalf_q <= RMODE_i;
                have_q  <= 1'b1;
            end
        end
    end

    assign rsel     = rsel_q;
    assign rhalf    = rhalf_q;
    assign RDATA_o  = have_q ? rdata_asm : '0;
    assign RVALID_o = rvalid_q;
`endif

    assign LEVEL_o        = cnt_q;
    assign EMPTY_o        = flags.empty;
    assign ALMOST_EMPTY_o = flags.almost_empty;
    assign UNDERRUN_o     = flags.underrun;
    assign FULL_o         = flags.full;
    assign ALMOST_FULL_o  = flags.almost_full;
    assign OVERRUN_o      = flags.overrun;
endmodule

// File: tb/tb_tdp_sync_fifo_ctl.sv
// Directed bench for tdp_sync_fifo_ctl (registered-read build), 32 half-word config.
module tb_tdp_sync_fifo_ctl;
  localparam int DW = 18;
  localparam int AW = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [8:0] exp_q[$];

  tdp_sync_fifo_ctl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo_if ();

  tdp_sync_fifo_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK_i          (clk),
    .RST_i          (rst),
    .FLUSH_i        (fifo_if.flush),
    .WMODE_i        (fifo_if.wmode),
    .RMODE_i        (fifo_if.rmode),
    .WEN_i          (fifo_if.wen),
    .WDATA_i        (fifo_if.wdata),
    .REN_i          (fifo_if.ren),
    .RDATA_o        (fifo_if.rdata),
    .RVALID_o       (fifo_if.rvalid),
    .UPAF_i         (fifo_if.upaf),
    .UPAE_i         (fifo_if.upae),
    .LEVEL_o        (fifo_if.level),
    .EMPTY_o        (fifo_if.empty),
    .ALMOST_EMPTY_o (fifo_if.almost_empty),
    .UNDERRUN_o     (fifo_if.underrun),
    .FULL_o         (fifo_if.full),
    .ALMOST_FULL_o  (fifo_if.almost_full),
    .OVERRUN_o      (fifo_if.overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: one clock per call, inputs return to idle afterwards
  task automatic cyc(input logic wen, input logic wmode, input logic [DW-1:0] wdata,
                     input logic ren, input logic rmode, input logic flush);
    fifo_if.wen   = wen;
    fifo_if.wmode = wmode;
    fifo_if.wdata = wdata;
    fifo_if.ren   = ren;
    fifo_if.rmode = rmode;
    fifo_if.flush = flush;
    @(posedge clk);
    #1;
    fifo_if.wen   = 1'b0;
    fifo_if.ren   = 1'b0;
    fifo_if.flush = 1'b0;
  endtask

  task automatic wr(input logic mode, input logic [DW-1:0] d);
    cyc(1'b1, mode, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic mode);
    cyc(1'b0, 1'b0, '0, 1'b1, mode, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    fifo_if.flush = 1'b0;
    fifo_if.wmode = 1'b0;
    fifo_if.rmode = 1'b0;
    fifo_if.wen   = 1'b0;
    fifo_if.ren   = 1'b0;
    fifo_if.wdata = '0;
    fifo_if.upaf  = 5'd4;
    fifo_if.upae  = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_level", 32'(fifo_if.level), 32'd0);
    check_eq("rst_empty", 32'(fifo_if.empty), 32'd1);
    check_eq("rst_full", 32'(fifo_if.full), 32'd0);
    check_eq("rst_ae", 32'(fifo_if.almost_empty), 32'd1);
    check_eq("rst_af", 32'(fifo_if.almost_full), 32'd0);
    check_eq("rst_rvalid", 32'(fifo_if.rvalid), 32'd0);
    check_eq("rst_rdata", 32'(fifo_if.rdata), 32'd0);
    check_eq("rst_ovr", 32'(fifo_if.overrun), 32'd0);
    check_eq("rst_und", 32'(fifo_if.underrun), 32'd0);

    // fill with 16 full words
    for (int k = 1; k <= 16; k++) begin
      wr(1'b0, DW'(k - 1));
      check_eq($sformatf("fill_level%0d", k), 32'(fifo_if.level), 32'(2 * k));
      check_eq($sformatf("fill_af%0d", k), 32'(fifo_if.almost_full), (k >= 14) ? 32'd1 : 32'd0);
      check_eq($sformatf("fill_full%0d", k), 32'(fifo_if.full), (k == 16) ? 32'd1 : 32'd0);
      check_eq($sformatf("fill_ae%0d", k), 32'(fifo_if.almost_empty), (k <= 2) ? 32'd1 : 32'd0);
    end
    wr(1'b0, 18'h3FFFF);
    check_eq("ovr_set", 32'(fifo_if.overrun), 32'd1);
    check_eq("ovr_level", 32'(fifo_if.level), 32'd32);

    // drain in order
    for (int k = 0; k < 16; k++) begin
      rd(1'b0);
      check_eq($sformatf("drain_rv%0d", k), 32'(fifo_if.rvalid), 32'd1);
      check_eq($sformatf("drain_data%0d", k), 32'(fifo_if.rdata), 32'(k));
    end
    check_eq("drain_empty", 32'(fifo_if.empty), 32'd1);
    check_eq("drain_level", 32'(fifo_if.level), 32'd0);
    rd(1'b0);
    check_eq("und_set", 32'(fifo_if.underrun), 32'd1);
    check_eq("und_rvalid", 32'(fifo_if.rvalid), 32'd0);
    check_eq("und_hold", 32'(fifo_if.rdata), 32'h0000F);

    // full write, half reads
    wr(1'b0, 18'h2AB55);
    rd(1'b1);
    check_eq("split1_lo", 32'(fifo_if.rdata), 32'h00155);
    rd(1'b1);
    check_eq("split1_hi", 32'(fifo_if.rdata), 32'h00155);
    wr(1'b0, 18'h3FE01);
    rd(1'b1);
    check_eq("split2_lo", 32'(fifo_if.rdata), 32'h00001);
    rd(1'b1);
    check_eq("split2_hi", 32'(fifo_if.rdata), 32'h001FF);

    // half writes, full read
    wr(1'b1, 18'h00011);
    wr(1'b1, 18'h00022);
    rd(1'b0);
    check_eq("merge", 32'(fifo_if.rdata), 32'h04411);

    // flush clears stickies
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("fl0_ovr", 32'(fifo_if.overrun), 32'd0);
    check_eq("fl0_und", 32'(fifo_if.underrun), 32'd0);
    check_eq("fl0_level", 32'(fifo_if.level), 32'd0);

    // simultaneous full write + full read at level 10
    for (int k = 0; k < 5; k++) wr(1'b0, DW'(18'h100 + k));
    check_eq("sim_pre", 32'(fifo_if.level), 32'd10);
    cyc(1'b1, 1'b0, 18'h105, 1'b1, 1'b0, 1'b0);
    check_eq("sim_level", 32'(fifo_if.level), 32'd10);
    check_eq("sim_data", 32'(fifo_if.rdata), 32'h00100);
    check_eq("sim_rv", 32'(fifo_if.rvalid), 32'd1);
    check_eq("sim_ae", 32'(fifo_if.almost_empty), 32'd0);
    check_eq("sim_af", 32'(fifo_if.almost_full), 32'd0);
    check_eq("sim_ovr", 32'(fifo_if.overrun), 32'd0);

    // level 31: full write blocked while half read accepted
    wr(1'b1, 18'h000AA);
    for (int k = 0; k < 10; k++) wr(1'b0, DW'(18'h200 + k));
    check_eq("l31_level", 32'(fifo_if.level), 32'd31);
    check_eq("l31_full", 32'(fifo_if.full), 32'd1);
    check_eq("l31_af", 32'(fifo_if.almost_full), 32'd1);
    cyc(1'b1, 1'b0, 18'h3ABCD, 1'b1, 1'b1, 1'b0);
    check_eq("l31_rej_level", 32'(fifo_if.level), 32'd30);
    check_eq("l31_rej_ovr", 32'(fifo_if.overrun), 32'd1);
    check_eq("l31_rd_data", 32'(fifo_if.rdata), 32'h00101);

    // flush at level 20 with overrun set and a write pending
    for (int k = 0; k < 5; k++) rd(1'b0);
    check_eq("fl_pre_level", 32'(fifo_if.level), 32'd20);
    cyc(1'b1, 1'b0, 18'h12345, 1'b0, 1'b0, 1'b1);
    check_eq("fl_level", 32'(fifo_if.level), 32'd0);
    check_eq("fl_empty", 32'(fifo_if.empty), 32'd1);
    check_eq("fl_ovr", 32'(fifo_if.overrun), 32'd0);
    check_eq("fl_rv", 32'(fifo_if.rvalid), 32'd0);
    check_eq("fl_rdata", 32'(fifo_if.rdata), 32'd0);

    // scoreboard: three fill/drain passes at odd half-word alignment
    wr(1'b1, 18'h001A5);
    exp_q.push_back(9'h1A5);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 15; i++) begin
        d = DW'(32'(c * 15 + i) * 32'h1357 + 32'h2A5A5);
        wr(1'b0, d);
        exp_q.push_back(d[8:0]);
        exp_q.push_back(d[17:9]);
      end
      check_eq($sformatf("wrap_full%0d", c), 32'(fifo_if.full), 32'd1);
      check_eq($sformatf("wrap_level%0d", c), 32'(fifo_if.level), 32'd31);
      for (int i = 0; i < 15; i++) begin
        logic [8:0] lo;
        logic [8:0] hi;
        lo = exp_q.pop_front();
        hi = exp_q.pop_front();
        rd(1'b0);
        check_eq($sformatf("wrap_c%0d_r%0d", c, i), 32'(fifo_if.rdata), 32'({hi, lo}));
      end
      check_eq($sformatf("wrap_drained%0d", c), 32'(fifo_if.level), 32'd1);
    end
    rd(1'b1);
    check_eq("wrap_tail", 32'(fifo_if.rdata), 32'(exp_q.pop_front()));
    check_eq("wrap_empty", 32'(fifo_if.empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
